// File: rtl/i2c_master_sequencer.sv
// I2C master bus sequencer: walks START, address, data, ACK, repeated-start and STOP phases,
// generating SCL timing and one-hot phase strobes for an external shift datapath.
module i2c_master_sequencer (
    input  logic       i2c_core_clock_i,
    input  logic       reset_bit_i,
    input  logic       enable_i,
    input  logic [7:0] addr_rw_i,
    input  logic [7:0] num_bytes_i,
    input  logic       repeat_start_i,
    input  logic [7:0] prescaler_i,
    input  logic       sda_i,
    input  logic [7:0] counter_data_ack_i,
    output logic       start_cnt_o,
    output logic       write_addr_cnt_o,
    output logic       write_data_cnt_o,
    output logic       read_data_cnt_o,
    output logic       write_ack_cnt_o,
    output logic       read_ack_cnt_o,
    output logic       stop_cnt_o,
    output logic       repeat_start_cnt_o,
    output logic [7:0] counter_detect_edge_o,
    output logic [7:0] counter_state_done_time_repeat_start_o,
    output logic       scl_o,
    output logic       ack_bit_o,
    output logic       data_req_o,
    output logic       rx_valid_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       nack_o
);

    typedef enum logic [3:0] {
        S_IDLE, S_START, S_WRITE_ADDR, S_READ_ADDR_ACK, S_WRITE_DATA,
        S_READ_DATA_ACK, S_READ_DATA, S_WRITE_ACK, S_REPEAT_START, S_STOP
    } state_t;

    state_t      r_state;
    logic [9:0]  r_cnt;
    logic [9:0]  r_rs_cnt;
    logic [7:0]  r_presc;
    logic [7:0]  r_addr_rw;
    logic [7:0]  r_bytes;
    logic        r_scl;
    logic        r_ack_bit;
    logic        r_data_req;
    logic        r_rx_valid;
    logic        r_busy;
    logic        r_done;
    logic        r_nack;

    // Counters are 10 bits wide so 2P-1 and 3P-1 never overflow for P up to 255.
    logic [9:0]  w_p;
    logic [9:0]  w_p2m1;
    logic [9:0]  w_p3m1;
    logic        w_period_end;
    logic [9:0]  w_cnt_next;
    logic        w_scl_next;
    logic        w_more;
    logic [7:0]  w_presc_in;
    state_t      w_end_state;

    assign w_p          = {2'b00, r_presc};
    assign w_p2m1       = (w_p << 1) - 10'd1;
    assign w_p3m1       = w_p + (w_p << 1) - 10'd1;
    assign w_period_end = (r_cnt == w_p2m1);
    assign w_cnt_next   = w_period_end ? 10'd0 : r_cnt + 10'd1;
    assign w_scl_next   = (w_cnt_next >= w_p);
    assign w_more       = (r_bytes > 8'd1);
    assign w_presc_in   = (prescaler_i < 8'd4) ? 8'd4 : prescaler_i;
    assign w_end_state  = repeat_start_i ? S_REPEAT_START : S_STOP;

    always_ff @(posedge i2c_core_clock_i or negedge reset_bit_i) begin
        if (!reset_bit_i) begin
            r_state    <= S_IDLE;
            r_cnt      <= 10'd0;
            r_rs_cnt   <= 10'd0;
            r_presc    <= 8'd4;
            r_addr_rw  <= 8'd0;
            r_bytes    <= 8'd0;
            r_scl      <= 1'b1;
            r_ack_bit  <= 1'b1;
            r_data_req <= 1'b0;
            r_rx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_nack     <= 1'b0;
        end else begin
            r_data_req <= 1'b0;
            r_rx_valid <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 10'd0;
                    r_scl <= 1'b1;
                    if (enable_i) begin
                        r_addr_rw <= addr_rw_i;
                        r_bytes   <= num_bytes_i;
                        r_presc   <= w_presc_in;
                        r_busy    <= 1'b1;
                        r_nack    <= 1'b0;
                        r_state   <= S_START;
                    end
                end
                S_START: begin
                    if (r_cnt == w_p - 10'd1) begin
                        r_cnt   <= 10'd0;
                        r_scl   <= 1'b0;
                        r_state <= S_WRITE_ADDR;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                    end
                end
                S_WRITE_ADDR, S_WRITE_DATA, S_READ_DATA: begin
                    r_cnt <= w_cnt_next;
                    r_scl <= w_scl_next;
                    if (w_period_end && counter_data_ack_i == 8'd2) begin
                        if (r_state == S_WRITE_ADDR) begin
                            r_state <= S_READ_ADDR_ACK;
                        end else if (r_state == S_WRITE_DATA) begin
                            r_state <= S_READ_DATA_ACK;
                        end else begin
                            r_rx_valid <= 1'b1;
                            r_ack_bit  <= (r_bytes <= 8'd1);
                            r_state    <= S_WRITE_ACK;
                        end
                    end
                end
                S_READ_ADDR_ACK: begin
                    r_cnt <= w_cnt_next;
                    r_scl <= w_scl_next;
                    if (w_period_end) begin
                        if (sda_i) begin
                            r_nack  <= 1'b1;
                            r_state <= S_STOP;
                        end else if (r_bytes != 8'd0) begin
                            if (r_addr_rw[0]) begin
                                r_state <= S_READ_DATA;
                            end else begin
                                r_data_req <= 1'b1;
                                r_state    <= S_WRITE_DATA;
                            end
                        end else begin
                            r_state <= w_end_state;
                        end
                    end
                end
                S_READ_DATA_ACK: begin
                    r_cnt <= w_cnt_next;
                    r_scl <= w_scl_next;
                    if (w_period_end) begin
                        if (sda_i) begin
                            r_nack  <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bytes <= r_bytes - 8'd1;
                            if (w_more) begin
                                r_data_req <= 1'b1;
                                r_state    <= S_WRITE_DATA;
                            end else begin
                                r_state <= w_end_state;
                            end
                        end
                    end
                end
                S_WRITE_ACK: begin
                    r_cnt <= w_cnt_next;
                    r_scl <= w_scl_next;
                    if (w_period_end) begin
                        r_bytes   <= r_bytes - 8'd1;
                        r_ack_bit <= 1'b1;
                        r_state   <= w_more ? S_READ_DATA : w_end_state;
                    end
                end
                // Address and byte count are re-sampled here so the follow-on transfer can differ.
                S_REPEAT_START: begin
                    r_cnt <= 10'd0;
                    if (r_rs_cnt == w_p3m1) begin
                        r_rs_cnt  <= 10'd0;
                        r_addr_rw <= addr_rw_i;
                        r_bytes   <= num_bytes_i;
                        r_scl     <= 1'b0;
                        r_state   <= S_WRITE_ADDR;
                    end else begin
                        r_rs_cnt <= r_rs_cnt + 10'd1;
                        r_scl    <= (r_rs_cnt + 10'd1 >= w_p);
                    end
                end
                S_STOP: begin
                    if (r_cnt == w_p2m1) begin
                        r_cnt   <= 10'd0;
                        r_scl   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 10'd1;
                        r_scl <= (r_cnt + 10'd1 >= w_p);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign start_cnt_o        = (r_state == S_START);
    assign write_addr_cnt_o   = (r_state == S_WRITE_ADDR);
    assign write_data_cnt_o   = (r_state == S_WRITE_DATA);
    assign read_data_cnt_o    = (r_state == S_READ_DATA);
    assign write_ack_cnt_o    = (r_state == S_WRITE_ACK);
    assign read_ack_cnt_o     = (r_state == S_READ_ADDR_ACK) || (r_state == S_READ_DATA_ACK);
    assign stop_cnt_o         = (r_state == S_STOP);
    assign repeat_start_cnt_o = (r_state == S_REPEAT_START);

    assign counter_detect_edge_o                  = r_cnt[7:0];
    assign counter_state_done_time_repeat_start_o = r_rs_cnt[7:0];
    assign scl_o      = r_scl;
    assign ack_bit_o  = r_ack_bit;
    assign data_req_o = r_data_req;
    assign rx_valid_o = r_rx_valid;
    assign busy_o     = r_busy;
    assign done_o     = r_done;
    assign nack_o     = r_nack;

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Directed bench for i2c_master_sequencer: models the datapath bit counter and a slave on SDA,
// then checks phase sequences, pulse counts and timing against hand-computed values.
module tb_i2c_master_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable_i = 1'b0;
    logic [7:0] addr_rw_i = 8'd0;
    logic [7:0] num_bytes_i = 8'd0;
    logic       repeat_start_i = 1'b0;
    logic [7:0] prescaler_i = 8'd4;
    logic       sda_i = 1'b0;
    logic [7:0] counter_data_ack_i;
    logic       start_cnt_o, write_addr_cnt_o, write_data_cnt_o, read_data_cnt_o;
    logic       write_ack_cnt_o, read_ack_cnt_o, stop_cnt_o, repeat_start_cnt_o;
    logic [7:0] counter_detect_edge_o, counter_state_done_time_repeat_start_o;
    logic       scl_o, ack_bit_o, data_req_o, rx_valid_o, busy_o, done_o, nack_o;

    always #5 clk = ~clk;

    i2c_master_sequencer dut (
        .i2c_core_clock_i(clk),
        .reset_bit_i(rst_n),
        .enable_i(enable_i),
        .addr_rw_i(addr_rw_i),
        .num_bytes_i(num_bytes_i),
        .repeat_start_i(repeat_start_i),
        .prescaler_i(prescaler_i),
        .sda_i(sda_i),
        .counter_data_ack_i(counter_data_ack_i),
        .start_cnt_o(start_cnt_o),
        .write_addr_cnt_o(write_addr_cnt_o),
        .write_data_cnt_o(write_data_cnt_o),
        .read_data_cnt_o(read_data_cnt_o),
        .write_ack_cnt_o(write_ack_cnt_o),
        .read_ack_cnt_o(read_ack_cnt_o),
        .stop_cnt_o(stop_cnt_o),
        .repeat_start_cnt_o(repeat_start_cnt_o),
        .counter_detect_edge_o(counter_detect_edge_o),
        .counter_state_done_time_repeat_start_o(counter_state_done_time_repeat_start_o),
        .scl_o(scl_o),
        .ack_bit_o(ack_bit_o),
        .data_req_o(data_req_o),
        .rx_valid_o(rx_valid_o),
        .busy_o(busy_o),
        .done_o(done_o),
        .nack_o(nack_o)
    );

    int assertCount = 0;
    int failCount = 0;
    int tbP = 4;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Datapath bit counter: loads 9 outside shift phases and counts down once per bit period.
    logic [7:0] dpCnt;
    assign counter_data_ack_i = dpCnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dpCnt <= 8'd9;
        end else if (write_addr_cnt_o || write_data_cnt_o || read_data_cnt_o) begin
            if (int'(counter_detect_edge_o) == 2 * tbP - 1) dpCnt <= dpCnt - 8'd1;
        end else begin
            dpCnt <= 8'd9;
        end
    end

    logic [7:0] strobeVec;
    logic [3:0] curCode;
    assign strobeVec = {start_cnt_o, write_addr_cnt_o, read_ack_cnt_o, write_data_cnt_o,
                        read_data_cnt_o, write_ack_cnt_o, repeat_start_cnt_o, stop_cnt_o};
    always_comb begin
        curCode = 4'd0;
        if (start_cnt_o)             curCode = 4'd1;
        else if (write_addr_cnt_o)   curCode = 4'd2;
        else if (read_ack_cnt_o)     curCode = 4'd3;
        else if (write_data_cnt_o)   curCode = 4'd4;
        else if (read_data_cnt_o)    curCode = 4'd5;
        else if (write_ack_cnt_o)    curCode = 4'd6;
        else if (repeat_start_cnt_o) curCode = 4'd7;
        else if (stop_cnt_o)         curCode = 4'd8;
    end

    logic        monitorClear = 1'b0;
    logic [63:0] seqWord;
    logic [3:0]  lastCode;
    logic [7:0]  ackSeq;
    logic        prevScl;
    int stateCycles [16];
    int dataReqCount, rxValidCount, doneCount, sclRises, maxEdge, maxTimer;
    int timerOutsideRs, multiStrobe, reqRun, maxReqRun, rxRun, maxRxRun;

    always @(negedge clk) begin
        if (monitorClear) begin
            seqWord = 64'd0; lastCode = curCode; ackSeq = 8'd0; prevScl = scl_o;
            for (int i = 0; i < 16; i++) stateCycles[i] = 0;
            dataReqCount = 0; rxValidCount = 0; doneCount = 0; sclRises = 0; maxEdge = 0;
            maxTimer = 0; timerOutsideRs = 0; multiStrobe = 0;
            reqRun = 0; maxReqRun = 0; rxRun = 0; maxRxRun = 0;
        end else begin
            stateCycles[curCode]++;
            if (curCode != lastCode) begin
                seqWord = (seqWord << 4) | 64'(curCode);
                lastCode = curCode;
                if (curCode == 4'd6) ackSeq = {ackSeq[6:0], ack_bit_o};
            end
            if (data_req_o) dataReqCount++;
            reqRun = data_req_o ? reqRun + 1 : 0;
            if (reqRun > maxReqRun) maxReqRun = reqRun;
            if (rx_valid_o) rxValidCount++;
            rxRun = rx_valid_o ? rxRun + 1 : 0;
            if (rxRun > maxRxRun) maxRxRun = rxRun;
            if (done_o) doneCount++;
            if (scl_o && !prevScl && curCode >= 4'd2 && curCode <= 4'd6) sclRises++;
            prevScl = scl_o;
            if (curCode >= 4'd2 && curCode <= 4'd6 && int'(counter_detect_edge_o) > maxEdge)
                maxEdge = int'(counter_detect_edge_o);
            if (int'(counter_state_done_time_repeat_start_o) > maxTimer)
                maxTimer = int'(counter_state_done_time_repeat_start_o);
            if (!repeat_start_cnt_o && counter_state_done_time_repeat_start_o != 8'd0) timerOutsideRs++;
            if ($countones(strobeVec) > 1) multiStrobe++;
        end
    end

    task automatic clearMonitor();
        monitorClear = 1'b1;
        @(negedge clk);
        #1 monitorClear = 1'b0;
    endtask

    task automatic applyStimulus(input logic [7:0] addr, input logic [7:0] nbytes,
                                 input logic rs, input logic [7:0] presc);
        @(negedge clk);
        addr_rw_i      = addr;
        num_bytes_i    = nbytes;
        repeat_start_i = rs;
        prescaler_i    = presc;
        tbP            = (presc < 8'd4) ? 4 : int'(presc);
        enable_i       = 1'b1;
        @(negedge clk);
        enable_i       = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int maxCycles);
        int n = 0;
        while (!done_o && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(n < maxCycles), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic waitStrobe(input string tag, input int sel, input int maxCycles);
        int n = 0;
        while (!((sel == 0) ? repeat_start_cnt_o : write_data_cnt_o) && n < maxCycles) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, 64'(n < maxCycles), 64'd1);
    endtask

    initial begin
        #12;
        checkOutput("rst_scl", 64'(scl_o), 64'd1);
        checkOutput("rst_strobes", 64'(strobeVec), 64'd0);
        checkOutput("rst_edge", 64'(counter_detect_edge_o), 64'd0);
        checkOutput("rst_timer", 64'(counter_state_done_time_repeat_start_o), 64'd0);
        checkOutput("rst_ackbit", 64'(ack_bit_o), 64'd1);
        checkOutput("rst_flags", 64'({data_req_o, rx_valid_o, busy_o, done_o, nack_o}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        clearMonitor();

        // 2-byte write at P=4, with a stray enable while busy
        sda_i = 1'b0;
        applyStimulus(8'hA0, 8'd2, 1'b0, 8'd4);
        checkOutput("A_busy", 64'(busy_o), 64'd1);
        repeat (20) @(negedge clk);
        addr_rw_i = 8'h55; num_bytes_i = 8'd5; enable_i = 1'b1;
        @(negedge clk);
        enable_i = 1'b0;
        waitDone("A_timeout", 2000);
        checkOutput("A_seq", seqWord, 64'h123434380);
        checkOutput("A_start_cycles", 64'(stateCycles[1]), 64'd4);
        checkOutput("A_stop_cycles", 64'(stateCycles[8]), 64'd8);
        checkOutput("A_data_req", 64'(dataReqCount), 64'd2);
        checkOutput("A_req_width", 64'(maxReqRun), 64'd1);
        checkOutput("A_done", 64'(doneCount), 64'd1);
        checkOutput("A_nack", 64'(nack_o), 64'd0);
        checkOutput("A_scl_high", 64'(sclRises), 64'd27);
        checkOutput("A_busy_end", 64'(busy_o), 64'd0);
        checkOutput("A_onehot", 64'(multiStrobe), 64'd0);
        clearMonitor();

        // 3-byte read at P=5
        applyStimulus(8'hA1, 8'd3, 1'b0, 8'd5);
        waitDone("B_timeout", 2000);
        checkOutput("B_seq", seqWord, 64'h12356565680);
        checkOutput("B_rx_valid", 64'(rxValidCount), 64'd3);
        checkOutput("B_rx_width", 64'(maxRxRun), 64'd1);
        checkOutput("B_ack_seq", 64'(ackSeq), 64'b001);
        checkOutput("B_start_cycles", 64'(stateCycles[1]), 64'd5);
        checkOutput("B_stop_cycles", 64'(stateCycles[8]), 64'd10);
        checkOutput("B_max_edge", 64'(maxEdge), 64'd9);
        checkOutput("B_data_req", 64'(dataReqCount), 64'd0);
        checkOutput("B_done", 64'(doneCount), 64'd1);
        checkOutput("B_ackbit_idle", 64'(ack_bit_o), 64'd1);
        clearMonitor();

        // slave NACKs the address
        sda_i = 1'b1;
        applyStimulus(8'hA0, 8'd2, 1'b0, 8'd4);
        waitDone("C_timeout", 2000);
        checkOutput("C_seq", seqWord, 64'h12380);
        checkOutput("C_nack", 64'(nack_o), 64'd1);
        checkOutput("C_data_req", 64'(dataReqCount), 64'd0);
        checkOutput("C_done", 64'(doneCount), 64'd1);
        sda_i = 1'b0;
        clearMonitor();

        // 1-byte write, repeated start, then 1-byte read to a new address
        applyStimulus(8'hA0, 8'd1, 1'b1, 8'd4);
        waitStrobe("D_rs_timeout", 0, 2000);
        addr_rw_i = 8'h51; num_bytes_i = 8'd1; repeat_start_i = 1'b0;
        waitDone("D_timeout", 2000);
        checkOutput("D_seq", seqWord, 64'h123437235680);
        checkOutput("D_rs_cycles", 64'(stateCycles[7]), 64'd12);
        checkOutput("D_max_timer", 64'(maxTimer), 64'd11);
        checkOutput("D_timer_outside", 64'(timerOutsideRs), 64'd0);
        checkOutput("D_rx_valid", 64'(rxValidCount), 64'd1);
        checkOutput("D_data_req", 64'(dataReqCount), 64'd1);
        checkOutput("D_ack_seq", 64'(ackSeq), 64'd1);
        checkOutput("D_nack_cleared", 64'(nack_o), 64'd0);
        clearMonitor();

        // prescaler below 4 behaves as 4; zero bytes is address only
        applyStimulus(8'hA0, 8'd0, 1'b0, 8'd2);
        waitDone("E_timeout", 2000);
        checkOutput("E_seq", seqWord, 64'h12380);
        checkOutput("E_start_cycles", 64'(stateCycles[1]), 64'd4);
        checkOutput("E_stop_cycles", 64'(stateCycles[8]), 64'd8);
        checkOutput("E_max_edge", 64'(maxEdge), 64'd7);
        checkOutput("E_scl_high", 64'(sclRises), 64'd9);
        clearMonitor();

        // asynchronous reset in the middle of a data byte
        applyStimulus(8'hA0, 8'd2, 1'b0, 8'd4);
        waitStrobe("F_wd_timeout", 1, 2000);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("F_strobes", 64'(strobeVec), 64'd0);
        checkOutput("F_scl", 64'(scl_o), 64'd1);
        checkOutput("F_edge", 64'(counter_detect_edge_o), 64'd0);
        checkOutput("F_ackbit", 64'(ack_bit_o), 64'd1);
        checkOutput("F_flags", 64'({data_req_o, rx_valid_o, busy_o, done_o, nack_o}), 64'd0);
        checkOutput("F_no_stop", 64'(stateCycles[8]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("F_idle_after", 64'({start_cnt_o, busy_o}), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
